// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32 instruction-fetch stage with IF/ID pipeline register (optional IF_STALL_CNT_EN stall counter)
module if_stage #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic [4:0]         if_id_rs1,
  output logic [4:0]         if_id_rs2
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    if_id_pc_q, if_id_pc_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic               if_id_valid_q, if_id_valid_d;

  // Next-state selection: flush beats stall, stall beats advance (reset handled in the register block)
  always_comb begin
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    if (flush) begin
      // Redirect to a word-aligned target and squash the slot behind it
      pc_d          = {branch_target[PC_W-1:2], 2'b00};
      if_id_pc_d    = '0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d          = pc_q + PC_W'(4);
      if_id_pc_d    = pc_q;
      if_id_instr_d = imem_rdata;
      if_id_valid_d = 1'b1;
    end
  end

  // PC and IF/ID registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of genuine stall cycles (a flush cycle is not a stall)
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  // Bubbles carry NOP (addi x0,x0,0) so these read as x0 and never trigger a hazard
  assign if_id_rs1   = if_id_instr_q[19:15];
  assign if_id_rs2   = if_id_instr_q[24:20];

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage against a rule-level fetch model
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;
`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
  logic        m_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .if_id_rs1     (if_id_rs1),
    .if_id_rs2     (if_id_rs2)
`ifdef IF_STALL_CNT_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: apply the per-edge rules directly
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'd0; m_ipc = 32'd0; m_instr = NOP; m_valid = 1'b0; m_cnt = 32'd0;
    end else begin
      if (stall && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (flush) begin
        m_pc = branch_target & ~32'd3; m_ipc = 32'd0; m_instr = NOP; m_valid = 1'b0;
      end else if (!stall) begin
        m_ipc = m_pc; m_instr = mem_word(m_pc); m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("imem_addr", imem_addr, m_pc);
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    chk("if_id_rs1", {27'd0, if_id_rs1}, {27'd0, m_instr[19:15]});
    chk("if_id_rs2", {27'd0, if_id_rs2}, {27'd0, m_instr[24:20]});
`ifdef IF_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, m_cnt);
`endif
  end

  task automatic cyc(input logic r, input logic s, input logic f, input logic [31:0] t);
    reset = r; stall = s; flush = f; branch_target = t;
    @(negedge clk);
  endtask

  initial begin
    // reset cycle
    @(negedge clk);
    chk("lit_reset_addr", imem_addr, 32'd0);
    chk("lit_reset_valid", {31'd0, if_id_valid}, 32'd0);
    chk("lit_reset_instr", if_id_instr, NOP);
    // free run
    cyc(0, 0, 0, 0);
    chk("lit_run_addr4", imem_addr, 32'd4);
    chk("lit_run_pc0", if_id_pc, 32'd0);
    chk("lit_run_instr0", if_id_instr, mem_word(32'd0));
    chk("lit_run_valid", {31'd0, if_id_valid}, 32'd1);
    cyc(0, 0, 0, 0);
    chk("lit_run_addr8", imem_addr, 32'd8);
    // stall 3 cycles at PC=8
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      chk("lit_stall_addr", imem_addr, 32'd8);
      chk("lit_stall_pc", if_id_pc, 32'd4);
    end
`ifdef IF_STALL_CNT_EN
    chk("lit_stall_cnt", stall_cycles, 32'd3);
`endif
    cyc(0, 0, 0, 0);
    chk("lit_resume_addr", imem_addr, 32'd12);
    chk("lit_resume_pc", if_id_pc, 32'd8);
    // flush to 0x40
    cyc(0, 0, 1, 32'h40);
    chk("lit_flush_addr", imem_addr, 32'h40);
    chk("lit_flush_instr", if_id_instr, NOP);
    chk("lit_flush_valid", {31'd0, if_id_valid}, 32'd0);
    chk("lit_flush_rs", {22'd0, if_id_rs1, if_id_rs2}, 32'd0);
    cyc(0, 0, 0, 0);
    chk("lit_target_pc", if_id_pc, 32'h40);
    chk("lit_target_valid", {31'd0, if_id_valid}, 32'd1);
    // flush wins over stall, target aligned
    cyc(0, 1, 1, 32'h103);
    chk("lit_fs_addr", imem_addr, 32'h100);
    chk("lit_fs_valid", {31'd0, if_id_valid}, 32'd0);
`ifdef IF_STALL_CNT_EN
    chk("lit_fs_cnt", stall_cycles, 32'd3);
`endif
    // wrap at top of address space
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("lit_wrap_addr", imem_addr, 32'd0);
    chk("lit_wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    // reset during stall at PC=0x20
    cyc(0, 0, 1, 32'h20);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("lit_rst_stall_addr", imem_addr, 32'd0);
    chk("lit_rst_stall_valid", {31'd0, if_id_valid}, 32'd0);
    chk("lit_rst_stall_instr", if_id_instr, NOP);
`ifdef IF_STALL_CNT_EN
    chk("lit_rst_stall_cnt", stall_cycles, 32'd0);
`endif
    cyc(0, 0, 0, 0);
    chk("lit_after_rst_pc", if_id_pc, 32'd0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 25),
          ($urandom_range(0, 99) < 10), $urandom);
    end
    cyc(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RISC-V core. Holds the PC, drives the instruction-memory address, and registers the fetched word into IF/ID. Consumes `stall` from the hazard detection unit and the EX-stage branch redirect. Feeds the rs1/rs2 fields back to hazard detection.

## Interface
- `PC_W`, 32: PC and address width.
- `INSTR_W`, 32: instruction width (fixed RV32, must be 32).
- `RESET_PC`, 0: PC value after reset.
- `NOP_INSTR`, 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  from hazard detection: hold PC and IF/ID.
- `flush`  in  1  branch/jump taken in EX: redirect and squash IF/ID.
- `branch_target`  in  PC_W  redirect address, valid when `flush`=1.
- `imem_addr`  out  PC_W  instruction memory address, equals current PC (combinational from PC reg).
- `imem_rdata`  in  INSTR_W  instruction word, combinational read of `imem_addr`, same cycle.
- `if_id_pc`  out  PC_W  PC of the instruction in IF/ID.
- `if_id_instr`  out  INSTR_W  registered instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `if_id_rs1`  out  5  `if_id_instr[19:15]`, combinational, to hazard detection.
- `if_id_rs2`  out  5  `if_id_instr[24:20]`, combinational, to hazard detection.

## Operation
- Per-cycle update priority: `reset` > `flush` > `stall` > normal advance.
- Reset: PC ← RESET_PC; `if_id_instr` ← NOP_INSTR; `if_id_pc` ← 0; `if_id_valid` ← 0. Counter (if compiled) ← 0.
- Flush: PC ← {`branch_target`[PC_W-1:2], 2'b00} (low two bits forced zero); IF/ID ← NOP_INSTR, `if_id_pc` ← 0, valid ← 0. Flush overrides a simultaneous stall.
- Stall (no flush): PC and all IF/ID registers hold; `imem_rdata` ignored.
- Advance: IF/ID ← {PC, `imem_rdata`}, valid ← 1; PC ← PC + 4 modulo 2^PC_W (wraps to 0 from 2^PC_W−4, no flag).
- Bubble rs fields are 0, so a squashed slot never causes a hazard stall (hazard unit ignores rd = x0).
- No internal FSM beyond PC/IF-ID registers; `stall` and `flush` are level signals sampled every edge, no handshake.

## Timing
- `imem_addr` valid in the same cycle the PC register updates; instruction memory read is zero-latency.
- Fetch latency: word at PC = A appears on `if_id_instr` one cycle after the cycle in which `imem_addr` = A (and no stall/flush).
- Stall of N cycles holds `imem_addr` and IF/ID constant for exactly N cycles; advance resumes the edge after `stall` falls.
- Branch penalty: `flush` sampled at edge k → edge k loads target into PC and bubble into IF/ID; instruction at target lands in IF/ID at edge k+1.
- Reset asserted mid-stream: next edge restores reset values regardless of `stall`/`flush`; first real instruction (at RESET_PC) in IF/ID one edge after `reset` deasserts.

## Configuration
- `IF_STALL_CNT_EN`: defined → adds output `stall_cycles` (32-bit) counting cycles where `stall`=1 and `flush`=0 and `reset`=0; saturates at 32'hFFFF_FFFF; cleared by `reset`. Undefined → port and counter absent; all other behaviour identical.

## Test plan
- Reset then 4 free-run cycles, imem returns addr-based words → `imem_addr` 0,4,8,12; `if_id_pc`/`if_id_instr` track one cycle behind; valid 0 during reset cycle, 1 after.
- Stall 3 cycles while PC=8 → `imem_addr` stays 8, IF/ID holds PC 4 instr for 3 cycles, advances to PC 8 on 4th edge; `stall_cycles`=3 if compiled.
- Flush with `branch_target`=0x40 → next cycle PC=0x40, `if_id_instr`=0x00000013, valid 0, rs1/rs2=0; following cycle `if_id_pc`=0x40, valid 1.
- `flush` and `stall` both high, target 0x103 → PC=0x100, bubble inserted, counter not incremented.
- PC_W=8, run to PC=0xFC → next PC 0x00, IF/ID shows PC 0xFC.
- Assert `reset` during active stall at PC=0x20 → next edge PC=RESET_PC, IF/ID NOP, valid 0, counter 0.
